// File: rtl/viterbi_pkg.sv
// Shared Viterbi definitions: trellis codeword lookup, state-index width and
// default rate-1/2, K=3 generator polynomials.
package viterbi_pkg;

    localparam int MAX_K = 7;
    localparam logic [2:0] DEF_G0 = 3'b111;
    localparam logic [2:0] DEF_G1 = 3'b101;

    function automatic int state_w(input int k);
        return $clog2(2 ** (k - 1));
    endfunction

    // r = {input bit, predecessor state}; result is the codeword index {c0,c1}
    function automatic logic [1:0] codeword(input logic [MAX_K-1:0] r,
                                            input logic [MAX_K-1:0] g0,
                                            input logic [MAX_K-1:0] g1);
        return {^(r & g0), ^(r & g1)};
    endfunction

endpackage

// File: rtl/acs_cell.sv
// One add-compare-select cell: two saturating candidate adders, select of the
// smaller survivor (even predecessor wins ties) and its decision bit.
module acs_cell #(
    parameter int BM_W = 3,
    parameter int PM_W = 8
) (
    input  logic [PM_W-1:0] pm_even,
    input  logic [PM_W-1:0] pm_odd,
    input  logic [BM_W-1:0] bm_even,
    input  logic [BM_W-1:0] bm_odd,
    output logic [PM_W-1:0] pm_sel,
    output logic            dec,
    output logic            sat
);

    function automatic logic [PM_W-1:0] sat_pm(input logic [PM_W:0] c);
        return c[PM_W] ? {PM_W{1'b1}} : c[PM_W-1:0];
    endfunction

    logic [PM_W:0]   cand_even;
    logic [PM_W:0]   cand_odd;
    logic [PM_W-1:0] clip_even;
    logic [PM_W-1:0] clip_odd;

    assign cand_even = {1'b0, pm_even} + {{(PM_W + 1 - BM_W){1'b0}}, bm_even};
    assign cand_odd  = {1'b0, pm_odd}  + {{(PM_W + 1 - BM_W){1'b0}}, bm_odd};
    assign clip_even = sat_pm(cand_even);
    assign clip_odd  = sat_pm(cand_odd);

    // Compare after clipping so two saturated candidates tie toward even
    always_comb begin
        if (clip_even <= clip_odd) begin
            pm_sel = clip_even;
            dec    = 1'b0;
            sat    = cand_even[PM_W];
        end else begin
            pm_sel = clip_odd;
            dec    = 1'b1;
            sat    = cand_odd[PM_W];
        end
    end

endmodule

// File: rtl/acsu_reg.sv
// Registered add-compare-select unit: holds all path metrics, normalises them,
// tracks the best state and hands survivor decisions to traceback via valid/ready.
module acsu_reg
    import viterbi_pkg::*;
#(
    parameter int           K         = 3,
    parameter logic [K-1:0] G0        = DEF_G0,
    parameter logic [K-1:0] G1        = DEF_G1,
    parameter int           BM_W      = 3,
    parameter int           PM_W      = 8,
    parameter int           INIT_BIAS = 64
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          start_i,
    input  logic                          bm_valid_i,
    output logic                          bm_ready_o,
    input  logic [4*BM_W-1:0]             bm_i,
    output logic                          dec_valid_o,
    input  logic                          dec_ready_i,
    output logic [2**(K-1)-1:0]           dec_bits_o,
    output logic [2**(K-1)*PM_W-1:0]      pm_o,
    output logic [K-2:0]                  best_state_o,
    output logic                          norm_o,
    output logic                          sat_o
);

    localparam int NS = 2 ** (K - 1);
    localparam int SW = state_w(K);

    function automatic logic [PM_W-1:0] start_pm(input int s);
        return (s == 0) ? '0 : PM_W'(INIT_BIAS);
    endfunction

    logic [PM_W-1:0] pm_q    [NS];
    logic [PM_W-1:0] base_pm [NS];
    logic [PM_W-1:0] acs_pm  [NS];
    logic [PM_W-1:0] next_pm [NS];
    logic [NS-1:0]   acs_dec;
    logic [NS-1:0]   acs_sat;
    logic [NS-1:0]   acs_msb;
    logic            norm_nxt;
    logic [SW-1:0]   best_nxt;
    logic [PM_W-1:0] best_val;
    logic            fire;

    assign bm_ready_o = !dec_valid_o || dec_ready_i;
    assign fire       = bm_valid_i && bm_ready_o;

    // A beat arriving together with start is computed from the start metrics
    always_comb begin
        for (int s = 0; s < NS; s++) begin
            base_pm[s] = start_i ? start_pm(s) : pm_q[s];
        end
    end

    for (genvar j = 0; j < NS; j++) begin : g_state
        localparam int P0  = 2 * (j % (NS / 2));
        localparam int B   = j / (NS / 2);
        localparam int R0  = B * NS + P0;
        localparam int CW0 = int'(codeword(MAX_K'(R0), MAX_K'(G0), MAX_K'(G1)));
        localparam int CW1 = int'(codeword(MAX_K'(R0 + 1), MAX_K'(G0), MAX_K'(G1)));

        acs_cell #(
            .BM_W (BM_W),
            .PM_W (PM_W)
        ) u_acs (
            .pm_even (base_pm[P0]),
            .pm_odd  (base_pm[P0 + 1]),
            .bm_even (bm_i[CW0*BM_W +: BM_W]),
            .bm_odd  (bm_i[CW1*BM_W +: BM_W]),
            .pm_sel  (acs_pm[j]),
            .dec     (acs_dec[j]),
            .sat     (acs_sat[j])
        );

        assign acs_msb[j]               = acs_pm[j][PM_W-1];
        assign pm_o[j*PM_W +: PM_W]     = pm_q[j];
    end

    // Subtracting 2**(PM_W-1) from every survivor keeps all differences intact
    assign norm_nxt = &acs_msb;

    always_comb begin
        for (int s = 0; s < NS; s++) begin
            next_pm[s] = acs_pm[s];
            if (norm_nxt) begin
                next_pm[s][PM_W-1] = 1'b0;
            end
        end
    end

    always_comb begin
        best_nxt = '0;
        best_val = next_pm[0];
        for (int s = 1; s < NS; s++) begin
            if (next_pm[s] < best_val) begin
                best_val = next_pm[s];
                best_nxt = SW'(s);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int s = 0; s < NS; s++) begin
                pm_q[s] <= start_pm(s);
            end
            dec_valid_o  <= 1'b0;
            dec_bits_o   <= '0;
            best_state_o <= '0;
            norm_o       <= 1'b0;
            sat_o        <= 1'b0;
        end else if (fire) begin
            for (int s = 0; s < NS; s++) begin
                pm_q[s] <= next_pm[s];
            end
            dec_valid_o  <= 1'b1;
            dec_bits_o   <= acs_dec;
            best_state_o <= best_nxt;
            norm_o       <= norm_nxt;
            sat_o        <= (sat_o && !start_i) || (|acs_sat);
        end else if (start_i) begin
            for (int s = 0; s < NS; s++) begin
                pm_q[s] <= start_pm(s);
            end
            dec_valid_o  <= 1'b0;
            dec_bits_o   <= '0;
            best_state_o <= '0;
            norm_o       <= 1'b0;
            sat_o        <= 1'b0;
        end else if (dec_ready_i) begin
            dec_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_acsu_reg.sv
// Bench for acsu_reg: vector table, normalisation and saturation sequences,
// then randomised traffic with a mid-stream reset against a behavioural model.
module tb_acsu_reg;

    localparam int NS   = 4;
    localparam int BIAS = 64;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        bm_valid_i;
    logic        dec_ready_i;
    logic [11:0] bm_i;

    logic        bm_ready_o, dec_valid_o, norm_o, sat_o;
    logic [3:0]  dec_bits_o;
    logic [31:0] pm_o;
    logic [1:0]  best_state_o;

    logic        s_bm_ready, s_dec_valid, s_norm, s_sat;
    logic [3:0]  s_dec_bits;
    logic [31:0] s_pm;
    logic [1:0]  s_best;

    acsu_reg dut (
        .clk_i (clk_i), .rst_i (rst_i), .start_i (start_i),
        .bm_valid_i (bm_valid_i), .bm_ready_o (bm_ready_o), .bm_i (bm_i),
        .dec_valid_o (dec_valid_o), .dec_ready_i (dec_ready_i),
        .dec_bits_o (dec_bits_o), .pm_o (pm_o), .best_state_o (best_state_o),
        .norm_o (norm_o), .sat_o (sat_o)
    );

    acsu_reg #(.INIT_BIAS (250)) dut_sat (
        .clk_i (clk_i), .rst_i (rst_i), .start_i (start_i),
        .bm_valid_i (bm_valid_i), .bm_ready_o (s_bm_ready), .bm_i (bm_i),
        .dec_valid_o (s_dec_valid), .dec_ready_i (dec_ready_i),
        .dec_bits_o (s_dec_bits), .pm_o (s_pm), .best_state_o (s_best),
        .norm_o (s_norm), .sat_o (s_sat)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] pm;
        logic [3:0]  dec;
        logic [1:0]  best;
        logic        norm;
    } snap_t;

    typedef struct {
        logic        st, v, rdy;
        logic [11:0] bm;
        logic        exp_rdy, exp_vld;
        logic [31:0] exp_pm;
        logic [3:0]  exp_dec;
        logic [1:0]  exp_best;
    } vec_t;

    snap_t q[$];
    vec_t  tbl[10];
    int    checks = 0;
    int    errors = 0;

    int         m_pm[NS];
    logic       m_valid, m_norm, m_sat;
    logic [3:0] m_dec;
    logic [1:0] m_best;

    function automatic logic [11:0] mk_bm(int a, int b, int c, int d);
        return {3'(d), 3'(c), 3'(b), 3'(a)};
    endfunction

    function automatic logic [31:0] mk_pm(int a, int b, int c, int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    function automatic logic [31:0] m_pack();
        return mk_pm(m_pm[0], m_pm[1], m_pm[2], m_pm[3]);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pm[0] = 0;
        for (int s = 1; s < NS; s++) m_pm[s] = BIAS;
        m_valid = 1'b0; m_norm = 1'b0; m_sat = 1'b0; m_dec = '0; m_best = '0;
        q.delete();
    endtask

    // Forward trellis walk: predecessor p with input b reaches state {b, p>>1}
    task automatic model_step(input logic st, input logic fire, input logic [11:0] bm, input logic rdy);
        int base[NS];
        int bv[NS];
        int bmv[4];
        int cand, j, r, idx, bi;
        logic [3:0] d, sv;
        logic sflag, nrm;
        snap_t sn;
        for (int s = 0; s < NS; s++) base[s] = st ? ((s == 0) ? 0 : BIAS) : m_pm[s];
        if (fire) begin
            for (int n = 0; n < 4; n++) bmv[n] = int'(bm[n*3 +: 3]);
            for (int s = 0; s < NS; s++) bv[s] = 1 << 30;
            d = '0; sv = '0;
            for (int p = 0; p < NS; p++) begin
                for (int b = 0; b < 2; b++) begin
                    j = b * (NS / 2) + (p >> 1);
                    r = b * NS + p;
                    idx = ($countones(r & 7) % 2) * 2 + ($countones(r & 5) % 2);
                    cand = base[p] + bmv[idx];
                    sflag = (cand > 255);
                    if (sflag) cand = 255;
                    if (cand < bv[j]) begin
                        bv[j] = cand;
                        d[j] = (p % 2) == 1;
                        sv[j] = sflag;
                    end
                end
            end
            nrm = 1'b1;
            for (int s = 0; s < NS; s++) if (bv[s] < 128) nrm = 1'b0;
            if (nrm) for (int s = 0; s < NS; s++) bv[s] -= 128;
            bi = 0;
            for (int s = 1; s < NS; s++) if (bv[s] < bv[bi]) bi = s;
            for (int s = 0; s < NS; s++) m_pm[s] = bv[s];
            m_dec = d; m_best = 2'(bi); m_norm = nrm;
            m_sat = (m_sat && !st) || (|sv);
            m_valid = 1'b1;
            sn.pm = m_pack(); sn.dec = d; sn.best = 2'(bi); sn.norm = nrm;
            q.push_back(sn);
        end else if (st) begin
            for (int s = 0; s < NS; s++) m_pm[s] = base[s];
            m_dec = '0; m_best = '0; m_norm = 1'b0; m_sat = 1'b0; m_valid = 1'b0;
        end else if (rdy) begin
            m_valid = 1'b0;
        end
    endtask

    // Drive one cycle, predict it, cross the edge and compare everything
    task automatic step(input logic st, input logic v, input logic [11:0] bm, input logic rdy,
                        output logic rdy_seen);
        logic exp_rdy, fire;
        snap_t sn;
        start_i = st; bm_valid_i = v; bm_i = bm; dec_ready_i = rdy;
        #1;
        rdy_seen = bm_ready_o;
        exp_rdy = !m_valid || rdy;
        chk("bm_ready", bm_ready_o, exp_rdy);
        fire = v && exp_rdy;
        model_step(st, fire, bm, rdy);
        @(posedge clk_i);
        #1;
        chk("dec_valid", dec_valid_o, m_valid);
        chk("sat", sat_o, m_sat);
        if (fire) begin
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL scoreboard: queue empty at %0t", $time);
            end else begin
                sn = q.pop_front();
                chk("pm_beat", pm_o, sn.pm);
                chk("dec_beat", dec_bits_o, sn.dec);
                chk("best_beat", best_state_o, sn.best);
                chk("norm_beat", norm_o, sn.norm);
            end
        end else begin
            chk("pm_hold", pm_o, m_pack());
            chk("dec_hold", dec_bits_o, m_dec);
            chk("best_hold", best_state_o, m_best);
            chk("norm_hold", norm_o, m_norm);
        end
    endtask

    task automatic reset_check(input string tag);
        chk({tag, "_pm"}, pm_o, mk_pm(0, 64, 64, 64));
        chk({tag, "_valid"}, dec_valid_o, 0);
        chk({tag, "_dec"}, dec_bits_o, 0);
        chk({tag, "_best"}, best_state_o, 0);
        chk({tag, "_norm"}, norm_o, 0);
        chk({tag, "_sat"}, sat_o, 0);
        chk({tag, "_pm_b250"}, s_pm, mk_pm(0, 250, 250, 250));
        chk({tag, "_sat_b250"}, s_sat, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (errors %0d)", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic rs;
        rst_i = 1'b1; start_i = 1'b0; bm_valid_i = 1'b0; dec_ready_i = 1'b0; bm_i = '0;
        model_reset();

        tbl[0] = '{1'b1, 1'b0, 1'b1, 12'h0,            1'b1, 1'b0, mk_pm(0, 64, 64, 64), 4'b0000, 2'd0};
        tbl[1] = '{1'b0, 1'b1, 1'b1, mk_bm(0, 2, 2, 4), 1'b1, 1'b1, mk_pm(0, 66, 4, 66),  4'b0000, 2'd0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, mk_bm(1, 1, 1, 1), 1'b0, 1'b1, mk_pm(0, 66, 4, 66),  4'b0000, 2'd0};
        tbl[3] = '{1'b0, 1'b1, 1'b0, mk_bm(1, 1, 1, 1), 1'b0, 1'b1, mk_pm(0, 66, 4, 66),  4'b0000, 2'd0};
        tbl[4] = '{1'b0, 1'b1, 1'b1, mk_bm(1, 1, 1, 1), 1'b1, 1'b1, mk_pm(1, 5, 1, 5),    4'b0000, 2'd0};
        tbl[5] = '{1'b0, 1'b1, 1'b1, mk_bm(7, 0, 7, 0), 1'b1, 1'b1, mk_pm(5, 5, 1, 1),    4'b0011, 2'd2};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 12'h0,            1'b1, 1'b0, mk_pm(5, 5, 1, 1),    4'b0011, 2'd2};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 12'h0,            1'b1, 1'b0, mk_pm(5, 5, 1, 1),    4'b0011, 2'd2};
        tbl[8] = '{1'b1, 1'b1, 1'b1, mk_bm(0, 2, 2, 4), 1'b1, 1'b1, mk_pm(0, 66, 4, 66),  4'b0000, 2'd0};
        tbl[9] = '{1'b1, 1'b0, 1'b0, 12'h0,            1'b0, 1'b0, mk_pm(0, 64, 64, 64), 4'b0000, 2'd0};

        repeat (2) @(posedge clk_i);
        #1;
        reset_check("reset");
        chk("reset_ready", bm_ready_o, 1);
        rst_i = 1'b0;

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].st, tbl[i].v, tbl[i].bm, tbl[i].rdy, rs);
            chk($sformatf("tbl%0d_ready", i), rs, tbl[i].exp_rdy);
            chk($sformatf("tbl%0d_valid", i), dec_valid_o, tbl[i].exp_vld);
            chk($sformatf("tbl%0d_pm", i), pm_o, tbl[i].exp_pm);
            chk($sformatf("tbl%0d_dec", i), dec_bits_o, tbl[i].exp_dec);
            chk($sformatf("tbl%0d_best", i), best_state_o, tbl[i].exp_best);
        end

        // Normalisation: all metrics meet at 7n from beat 2 and wrap at beat 19
        step(1'b1, 1'b0, 12'h0, 1'b1, rs);
        for (int n = 1; n <= 20; n++) begin
            step(1'b0, 1'b1, mk_bm(7, 7, 7, 7), 1'b1, rs);
            if (n == 18) begin
                chk("norm18_flag", norm_o, 0);
                chk("norm18_pm", pm_o, mk_pm(126, 126, 126, 126));
            end
            if (n == 19) begin
                chk("norm19_flag", norm_o, 1);
                chk("norm19_pm", pm_o, mk_pm(5, 5, 5, 5));
                chk("norm19_best", best_state_o, 0);
            end
            if (n == 20) begin
                chk("norm20_flag", norm_o, 0);
                chk("norm20_pm", pm_o, mk_pm(12, 12, 12, 12));
            end
        end

        // Saturation on the INIT_BIAS=250 instance
        step(1'b1, 1'b0, 12'h0, 1'b1, rs);
        chk("sat_start_pm", s_pm, mk_pm(0, 250, 250, 250));
        step(1'b0, 1'b1, mk_bm(7, 7, 7, 7), 1'b1, rs);
        chk("sat_beat_pm", s_pm, mk_pm(7, 255, 7, 255));
        chk("sat_beat_flag", s_sat, 1);
        chk("sat_beat_valid", s_dec_valid, 1);
        step(1'b0, 1'b1, mk_bm(0, 0, 0, 0), 1'b1, rs);
        chk("sat_sticky_pm", s_pm, mk_pm(7, 7, 7, 7));
        chk("sat_sticky_flag", s_sat, 1);
        step(1'b0, 1'b0, 12'h0, 1'b1, rs);
        chk("sat_idle_flag", s_sat, 1);
        step(1'b1, 1'b0, 12'h0, 1'b1, rs);
        chk("sat_clear_flag", s_sat, 0);
        chk("sat_clear_pm", s_pm, mk_pm(0, 250, 250, 250));

        // Random traffic with an asynchronous reset in the middle
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                #2;
                rst_i = 1'b1;
                #1;
                reset_check("async_rst");
                model_reset();
                @(posedge clk_i);
                #1;
                reset_check("rst_held");
                rst_i = 1'b0;
            end
            step($urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0,
                 12'($urandom), $urandom_range(0, 3) != 0, rs);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
